// File: rtl/reg_file_sb_if.sv
// Writeback/decode bundle for the register file and scoreboard.
// Latency: wires only.
// Backpressure: none here; stall travels back to decode on this bundle.
interface reg_file_sb_if #(
    parameter int NREGS = 16,
    parameter int DW    = 32
);
    localparam int AW = $clog2(NREGS);

    // Writeback commit
    logic [AW-1:0] wb_reg_num;
    logic          wb_write_en;
    logic [DW-1:0] wb_reg_value;
    logic          wb_flags_en;
    logic [3:0]    wb_flags;

    // Decode read ports
    logic [AW-1:0] rs_num;
    logic [AW-1:0] rt_num;
    logic          rs_en;
    logic          rt_en;
    logic [DW-1:0] rs_val;
    logic [DW-1:0] rt_val;

    // Decode issue / hazard check
    logic          issue_en;
    logic          issue_wr;
    logic [AW-1:0] issue_rd;
    logic          stall;
    logic [3:0]    cpsr_flags;

    // Pipeline side (writeback + decode) drives requests
    modport master (
        output wb_reg_num, wb_write_en, wb_reg_value, wb_flags_en, wb_flags,
        output rs_num, rt_num, rs_en, rt_en, issue_en, issue_wr, issue_rd,
        input  rs_val, rt_val, stall, cpsr_flags
    );

    // Register file side
    modport slave (
        input  wb_reg_num, wb_write_en, wb_reg_value, wb_flags_en, wb_flags,
        input  rs_num, rt_num, rs_en, rt_en, issue_en, issue_wr, issue_rd,
        output rs_val, rt_val, stall, cpsr_flags
    );
endinterface

// File: rtl/reg_file_sb.sv
// Register file + CPSR + busy scoreboard with write-through read bypass.
// Latency: reads and stall combinational; writes/flags/busy update at the clk edge.
// Backpressure: stall blocks decode issue on RAW/WAW against in-flight writers.
module reg_file_sb #(
    parameter int NREGS = 16,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    reg_file_sb_if.slave  rf
);
    logic [DW-1:0]    regs [NREGS];
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] wb_hit;
    logic [NREGS-1:0] set_vec;
    logic [NREGS-1:0] eff_busy;
    logic [3:0]       cpsr;
    logic             stall_int;
    logic             issue_fire;

    // One-hot of the register being written back this cycle; its busy bit is treated as already cleared
    always_comb begin
        wb_hit = '0;
        if (rf.wb_write_en) begin
            wb_hit[rf.wb_reg_num] = 1'b1;
        end
        eff_busy = busy & ~wb_hit;
    end

    // Read ports with bypass so a committing value is visible in the same cycle
    always_comb begin
        rf.rs_val = regs[rf.rs_num];
        rf.rt_val = regs[rf.rt_num];
        if (rf.wb_write_en && (rf.wb_reg_num == rf.rs_num)) begin
            rf.rs_val = rf.wb_reg_value;
        end
        if (rf.wb_write_en && (rf.wb_reg_num == rf.rt_num)) begin
            rf.rt_val = rf.wb_reg_value;
        end
    end

    // Hazard check: source operands (RAW) and the destination (WAW, one writer per register)
    always_comb begin
        stall_int = rf.issue_en &
                    ((rf.rs_en    & eff_busy[rf.rs_num]) |
                     (rf.rt_en    & eff_busy[rf.rt_num]) |
                     (rf.issue_wr & eff_busy[rf.issue_rd]));
        issue_fire = rf.issue_en & rf.issue_wr & ~stall_int;
        set_vec    = '0;
        if (issue_fire) begin
            set_vec[rf.issue_rd] = 1'b1;
        end
        rf.stall      = stall_int;
        rf.cpsr_flags = cpsr;
    end

    // Register array commit
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (rf.wb_write_en) begin
            regs[rf.wb_reg_num] <= rf.wb_reg_value;
        end
    end

    // Scoreboard: writeback clears, accepted issue sets; set wins on the same register
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= (busy & ~wb_hit) | set_vec;
        end
    end

    // CPSR flags, registered and not bypassed
    always_ff @(posedge clk) begin
        if (rst) begin
            cpsr <= 4'b0000;
        end else if (rf.wb_flags_en) begin
            cpsr <= rf.wb_flags;
        end
    end
endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: directed scenarios then random traffic vs a reference model.
// Latency: inputs driven at negedge, outputs sampled #1 later, model advances at each posedge.
// Backpressure: stall is checked against the model's in-flight writer list.
module tb_reg_file_sb;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    reg_file_sb_if #(.NREGS(16), .DW(32)) rf_bus ();

    reg_file_sb #(.NREGS(16), .DW(32)) dut (
        .clk (clk),
        .rst (rst),
        .rf  (rf_bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: register contents, flags, and a list of registers with an in-flight writer
    logic [31:0] m_regs [16];
    logic [3:0]  m_cpsr;
    int          m_inflight [$];

    function automatic bit m_pending(input int r);
        foreach (m_inflight[i]) if (m_inflight[i] == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_blocked(input int r);
        if (rf_bus.wb_write_en && int'(rf_bus.wb_reg_num) == r) return 1'b0;
        return m_pending(r);
    endfunction

    function automatic logic [31:0] m_read(input int r);
        if (rf_bus.wb_write_en && int'(rf_bus.wb_reg_num) == r) return rf_bus.wb_reg_value;
        return m_regs[r];
    endfunction

    function automatic bit m_stall();
        if (!rf_bus.issue_en) return 1'b0;
        if (rf_bus.rs_en && m_blocked(int'(rf_bus.rs_num))) return 1'b1;
        if (rf_bus.rt_en && m_blocked(int'(rf_bus.rt_num))) return 1'b1;
        if (rf_bus.issue_wr && m_blocked(int'(rf_bus.issue_rd))) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drive_idle();
        rst                 = 1'b0;
        rf_bus.wb_reg_num   = '0;
        rf_bus.wb_write_en  = 1'b0;
        rf_bus.wb_reg_value = '0;
        rf_bus.wb_flags_en  = 1'b0;
        rf_bus.wb_flags     = '0;
        rf_bus.rs_num       = '0;
        rf_bus.rt_num       = '0;
        rf_bus.rs_en        = 1'b0;
        rf_bus.rt_en        = 1'b0;
        rf_bus.issue_en     = 1'b0;
        rf_bus.issue_wr     = 1'b0;
        rf_bus.issue_rd     = '0;
    endtask

    // Advance one clock: model consumes the currently driven inputs, then return to the negedge
    task automatic tick();
        bit s;
        int wr;
        s = m_stall();
        if (rst) begin
            foreach (m_regs[i]) m_regs[i] = '0;
            m_cpsr = 4'b0000;
            m_inflight.delete();
        end else begin
            if (rf_bus.wb_write_en) begin
                wr = int'(rf_bus.wb_reg_num);
                m_regs[wr] = rf_bus.wb_reg_value;
                for (int i = m_inflight.size() - 1; i >= 0; i--)
                    if (m_inflight[i] == wr) m_inflight.delete(i);
            end
            if (rf_bus.issue_en && rf_bus.issue_wr && !s && !m_pending(int'(rf_bus.issue_rd)))
                m_inflight.push_back(int'(rf_bus.issue_rd));
            if (rf_bus.wb_flags_en) m_cpsr = rf_bus.wb_flags;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        drive_idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rf_bus.rs_num = 4'd3; rf_bus.rt_num = 4'd15;
        rf_bus.rs_en = 1'b1; rf_bus.rt_en = 1'b1;
        rf_bus.issue_en = 1'b1; rf_bus.issue_wr = 1'b1; rf_bus.issue_rd = 4'd7;
        #1;
        n_checks++; if (rf_bus.rs_val !== 32'h0) begin n_errors++; $display("FAIL reset_rs_val got %h want 0", rf_bus.rs_val); end
        n_checks++; if (rf_bus.rt_val !== 32'h0) begin n_errors++; $display("FAIL reset_rt_val got %h want 0", rf_bus.rt_val); end
        n_checks++; if (rf_bus.cpsr_flags !== 4'b0000) begin n_errors++; $display("FAIL reset_cpsr got %b want 0000", rf_bus.cpsr_flags); end
        n_checks++; if (rf_bus.stall !== 1'b0) begin n_errors++; $display("FAIL reset_stall got %b want 0", rf_bus.stall); end
        drive_idle();
    endtask

    task automatic test_bypass();
        drive_idle();
        rf_bus.wb_write_en = 1'b1; rf_bus.wb_reg_num = 4'd5; rf_bus.wb_reg_value = 32'hDEADBEEF;
        rf_bus.rs_num = 4'd5; rf_bus.rt_num = 4'd6;
        #1;
        n_checks++; if (rf_bus.rs_val !== 32'hDEADBEEF) begin n_errors++; $display("FAIL bypass_same_cycle got %h want deadbeef", rf_bus.rs_val); end
        n_checks++; if (rf_bus.rt_val !== 32'h0) begin n_errors++; $display("FAIL bypass_other_port got %h want 0", rf_bus.rt_val); end
        tick();
        drive_idle();
        rf_bus.rs_num = 4'd5; rf_bus.rt_num = 4'd5;
        #1;
        n_checks++; if (rf_bus.rs_val !== 32'hDEADBEEF) begin n_errors++; $display("FAIL stored_rs got %h want deadbeef", rf_bus.rs_val); end
        n_checks++; if (rf_bus.rt_val !== 32'hDEADBEEF) begin n_errors++; $display("FAIL stored_rt_same_reg got %h want deadbeef", rf_bus.rt_val); end
        rf_bus.wb_write_en = 1'b1; rf_bus.wb_reg_num = 4'd5; rf_bus.wb_reg_value = 32'h1234_5678;
        #1;
        n_checks++; if (rf_bus.rs_val !== 32'h1234_5678 || rf_bus.rt_val !== 32'h1234_5678) begin
            n_errors++; $display("FAIL bypass_both_ports got %h/%h want 12345678", rf_bus.rs_val, rf_bus.rt_val); end
        tick();
        drive_idle();
    endtask

    task automatic test_raw();
        drive_idle();
        rf_bus.issue_en = 1'b1; rf_bus.issue_wr = 1'b1; rf_bus.issue_rd = 4'd2;
        #1;
        n_checks++; if (rf_bus.stall !== 1'b0) begin n_errors++; $display("FAIL raw_first_issue got %b want 0", rf_bus.stall); end
        tick();
        drive_idle();
        rf_bus.issue_en = 1'b1; rf_bus.rs_en = 1'b1; rf_bus.rs_num = 4'd2;
        #1;
        n_checks++; if (rf_bus.stall !== 1'b1) begin n_errors++; $display("FAIL raw_stall got %b want 1", rf_bus.stall); end
        rf_bus.issue_en = 1'b0;
        #1;
        n_checks++; if (rf_bus.stall !== 1'b0) begin n_errors++; $display("FAIL raw_no_issue got %b want 0", rf_bus.stall); end
        rf_bus.issue_en = 1'b1;
        rf_bus.wb_write_en = 1'b1; rf_bus.wb_reg_num = 4'd2; rf_bus.wb_reg_value = 32'h7;
        #1;
        n_checks++; if (rf_bus.stall !== 1'b0) begin n_errors++; $display("FAIL raw_wb_release got %b want 0", rf_bus.stall); end
        n_checks++; if (rf_bus.rs_val !== 32'h7) begin n_errors++; $display("FAIL raw_wb_value got %h want 7", rf_bus.rs_val); end
        tick();
        drive_idle();
    endtask

    task automatic test_waw();
        drive_idle();
        rf_bus.issue_en = 1'b1; rf_bus.issue_wr = 1'b1; rf_bus.issue_rd = 4'd4;
        tick();
        #1;
        n_checks++; if (rf_bus.stall !== 1'b1) begin n_errors++; $display("FAIL waw_stall got %b want 1", rf_bus.stall); end
        rf_bus.wb_write_en = 1'b1; rf_bus.wb_reg_num = 4'd4; rf_bus.wb_reg_value = 32'h44;
        #1;
        n_checks++; if (rf_bus.stall !== 1'b0) begin n_errors++; $display("FAIL waw_wb_release got %b want 0", rf_bus.stall); end
        tick();
        drive_idle();
        rf_bus.issue_en = 1'b1; rf_bus.rs_en = 1'b1; rf_bus.rs_num = 4'd4;
        #1;
        n_checks++; if (rf_bus.stall !== 1'b1) begin n_errors++; $display("FAIL set_wins_busy got %b want 1", rf_bus.stall); end
        drive_idle();
        rf_bus.wb_write_en = 1'b1; rf_bus.wb_reg_num = 4'd8; rf_bus.wb_reg_value = 32'h88;
        tick();
        drive_idle();
        rf_bus.issue_en = 1'b1; rf_bus.rt_en = 1'b1; rf_bus.rt_num = 4'd8;
        #1;
        n_checks++; if (rf_bus.stall !== 1'b0 || rf_bus.rt_val !== 32'h88) begin
            n_errors++; $display("FAIL wb_non_busy got stall %b val %h want 0 00000088", rf_bus.stall, rf_bus.rt_val); end
        drive_idle();
        rf_bus.wb_write_en = 1'b1; rf_bus.wb_reg_num = 4'd4; rf_bus.wb_reg_value = 32'h45;
        tick();
        drive_idle();
    endtask

    task automatic test_flags();
        drive_idle();
        rf_bus.wb_flags_en = 1'b1; rf_bus.wb_flags = 4'b0110;
        rf_bus.wb_write_en = 1'b1; rf_bus.wb_reg_num = 4'd1; rf_bus.wb_reg_value = 32'hA5A5_0001;
        #1;
        n_checks++; if (rf_bus.cpsr_flags !== 4'b0000) begin n_errors++; $display("FAIL flags_not_bypassed got %b want 0000", rf_bus.cpsr_flags); end
        tick();
        drive_idle();
        rf_bus.rs_num = 4'd1;
        rf_bus.wb_flags = 4'b1111;
        #1;
        n_checks++; if (rf_bus.cpsr_flags !== 4'b0110) begin n_errors++; $display("FAIL flags_commit got %b want 0110", rf_bus.cpsr_flags); end
        n_checks++; if (rf_bus.rs_val !== 32'hA5A5_0001) begin n_errors++; $display("FAIL flags_concurrent_wr got %h want a5a50001", rf_bus.rs_val); end
        tick();
        #1;
        n_checks++; if (rf_bus.cpsr_flags !== 4'b0110) begin n_errors++; $display("FAIL flags_hold got %b want 0110", rf_bus.cpsr_flags); end
        drive_idle();
    endtask

    task automatic test_reset_mid();
        drive_idle();
        rf_bus.issue_en = 1'b1; rf_bus.issue_wr = 1'b1; rf_bus.issue_rd = 4'd1;
        tick();
        rf_bus.issue_rd = 4'd9;
        rf_bus.wb_write_en = 1'b1; rf_bus.wb_reg_num = 4'd9; rf_bus.wb_reg_value = 32'h55;
        tick();
        drive_idle();
        rf_bus.issue_en = 1'b1; rf_bus.rs_en = 1'b1; rf_bus.rs_num = 4'd9;
        #1;
        n_checks++; if (rf_bus.stall !== 1'b1 || rf_bus.rs_val !== 32'h55) begin
            n_errors++; $display("FAIL mid_setup got stall %b val %h want 1 00000055", rf_bus.stall, rf_bus.rs_val); end
        drive_idle();
        rst = 1'b1;
        rf_bus.wb_write_en = 1'b1; rf_bus.wb_reg_num = 4'd9; rf_bus.wb_reg_value = 32'h99;
        rf_bus.wb_flags_en = 1'b1; rf_bus.wb_flags = 4'b1010;
        rf_bus.issue_en = 1'b1; rf_bus.issue_wr = 1'b1; rf_bus.issue_rd = 4'd3;
        tick();
        drive_idle();
        rf_bus.issue_en = 1'b1; rf_bus.rs_en = 1'b1; rf_bus.rs_num = 4'd9;
        rf_bus.rt_en = 1'b1; rf_bus.rt_num = 4'd1;
        rf_bus.issue_wr = 1'b1; rf_bus.issue_rd = 4'd3;
        #1;
        n_checks++; if (rf_bus.stall !== 1'b0) begin n_errors++; $display("FAIL mid_reset_stall got %b want 0", rf_bus.stall); end
        n_checks++; if (rf_bus.rs_val !== 32'h0) begin n_errors++; $display("FAIL mid_reset_r9 got %h want 0", rf_bus.rs_val); end
        n_checks++; if (rf_bus.cpsr_flags !== 4'b0000) begin n_errors++; $display("FAIL mid_reset_cpsr got %b want 0000", rf_bus.cpsr_flags); end
        rf_bus.issue_en = 1'b0;
        drive_idle();
    endtask

    task automatic test_random();
        logic [31:0] e_rs, e_rt;
        bit e_stall;
        drive_idle();
        for (int cyc = 0; cyc < 600; cyc++) begin
            rst = ($urandom_range(0, 79) == 0);
            rf_bus.wb_write_en = $urandom_range(0, 1);
            if (m_inflight.size() > 0 && $urandom_range(0, 2) != 0)
                rf_bus.wb_reg_num = 4'(m_inflight[$urandom_range(0, m_inflight.size() - 1)]);
            else
                rf_bus.wb_reg_num = 4'($urandom_range(0, 15));
            rf_bus.wb_reg_value = $urandom;
            rf_bus.wb_flags_en  = $urandom_range(0, 1);
            rf_bus.wb_flags     = 4'($urandom_range(0, 15));
            rf_bus.rs_num       = 4'($urandom_range(0, 15));
            rf_bus.rt_num       = ($urandom_range(0, 3) == 0) ? rf_bus.rs_num : 4'($urandom_range(0, 15));
            rf_bus.rs_en        = $urandom_range(0, 1);
            rf_bus.rt_en        = $urandom_range(0, 1);
            rf_bus.issue_en     = $urandom_range(0, 1);
            rf_bus.issue_wr     = $urandom_range(0, 1);
            rf_bus.issue_rd     = 4'($urandom_range(0, 15));
            #1;
            e_rs = m_read(int'(rf_bus.rs_num));
            e_rt = m_read(int'(rf_bus.rt_num));
            e_stall = m_stall();
            n_checks++; if (rf_bus.rs_val !== e_rs) begin n_errors++; $display("FAIL rand_rs cyc %0d got %h want %h", cyc, rf_bus.rs_val, e_rs); end
            n_checks++; if (rf_bus.rt_val !== e_rt) begin n_errors++; $display("FAIL rand_rt cyc %0d got %h want %h", cyc, rf_bus.rt_val, e_rt); end
            n_checks++; if (rf_bus.stall !== e_stall) begin n_errors++; $display("FAIL rand_stall cyc %0d got %b want %b", cyc, rf_bus.stall, e_stall); end
            n_checks++; if (rf_bus.cpsr_flags !== m_cpsr) begin n_errors++; $display("FAIL rand_cpsr cyc %0d got %b want %b", cyc, rf_bus.cpsr_flags, m_cpsr); end
            tick();
        end
        drive_idle();
    endtask

    initial begin
        foreach (m_regs[i]) m_regs[i] = '0;
        m_cpsr = 4'b0000;
        drive_idle();
        rst = 1'b1;
        @(negedge clk);
        test_reset();
        test_bypass();
        test_raw();
        test_waw();
        test_flags();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
